icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 162 ++++++++++++++++
 tb/tb_icache.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one 32-bit word per line,
// single outstanding miss to the memory controller.
// Optional feature macro: ICACHE_STORAGE_EN. When defined, the line store is
// built and lookups can hit. When undefined, every request takes the miss path
// and no lines are written.
module icache #(
  parameter int unsigned ICACHE_INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        ic_mem_ask,
  output logic [31:0] ic_mem_addr,
  input  logic        ic_mem_valid,
  input  logic [31:0] ic_mem_inst,
  input  logic        rob_clear
);

  localparam int unsigned LINES = 1 << ICACHE_INDEX_BITS;
  localparam int unsigned TAG_W = 30 - ICACHE_INDEX_BITS;
  localparam int unsigned IDX_LO = 2;
  localparam int unsigned IDX_HI = ICACHE_INDEX_BITS + 1;
  localparam int unsigned TAG_LO = ICACHE_INDEX_BITS + 2;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic        r_mem_ask;
  logic [31:0] r_mem_addr;
  logic        r_discard;

  logic        w_if_valid_nxt;
  logic [31:0] w_if_inst_nxt;
  logic        w_mem_ask_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic        w_discard_nxt;

  logic [31:0] w_pc_aligned;
  logic        w_hit;
  logic [31:0] w_hit_data;

  assign w_pc_aligned = if_pc & 32'hFFFF_FFFC;

  assign if_valid    = r_if_valid;
  assign if_inst     = r_if_inst;
  assign ic_mem_ask  = r_mem_ask;
  assign ic_mem_addr = r_mem_addr;

`ifdef ICACHE_STORAGE_EN
  logic [LINES-1:0]             r_line_valid;
  logic [TAG_W-1:0]             r_line_tag  [LINES];
  logic [31:0]                  r_line_data [LINES];

  logic [ICACHE_INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]             w_tag;
  logic [ICACHE_INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_W-1:0]             w_fill_tag;
  logic                         w_fill;

  // Lookup fields come from the live pc; fill fields from the latched miss address.
  assign w_idx      = w_pc_aligned[IDX_HI:IDX_LO];
  assign w_tag      = w_pc_aligned[31:TAG_LO];
  assign w_fill_idx = r_mem_addr[IDX_HI:IDX_LO];
  assign w_fill_tag = r_mem_addr[31:TAG_LO];
  assign w_fill     = (r_state == MISS) && ic_mem_valid;

  assign w_hit      = r_line_valid[w_idx] && (r_line_tag[w_idx] == w_tag);
  assign w_hit_data = r_line_data[w_idx];

  // Line valid bits: cleared on reset, set on fill; flush never touches them.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_line_valid <= '0;
    end else if (rdy_in && w_fill) begin
      r_line_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays, written on fill; contents are don't-care until valid.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && w_fill) begin
      r_line_tag[w_fill_idx]  <= w_fill_tag;
      r_line_data[w_fill_idx] <= ic_mem_inst;
    end
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = 32'h0;
`endif

  // State and output registers; rdy_in low freezes everything except reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_if_valid <= 1'b0;
      r_if_inst  <= 32'h0;
      r_mem_ask  <= 1'b0;
      r_mem_addr <= 32'h0;
      r_discard  <= 1'b0;
    end else if (rdy_in) begin
      r_state    <= w_state_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_inst  <= w_if_inst_nxt;
      r_mem_ask  <= w_mem_ask_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_discard  <= w_discard_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_if_valid_nxt = 1'b0;
    w_if_inst_nxt  = r_if_inst;
    w_mem_ask_nxt  = r_mem_ask;
    w_mem_addr_nxt = r_mem_addr;
    w_discard_nxt  = r_discard;

    unique case (r_state)
      IDLE: begin
        // A request is not re-accepted in the cycle its result is presented.
        if (if_req && !r_if_valid && !rob_clear) begin
          if (w_hit) begin
            w_if_valid_nxt = 1'b1;
            w_if_inst_nxt  = w_hit_data;
          end else begin
            w_mem_ask_nxt  = 1'b1;
            w_mem_addr_nxt = w_pc_aligned;
            w_discard_nxt  = 1'b0;
            w_state_nxt    = MISS;
          end
        end
      end
      MISS: begin
        if (ic_mem_valid) begin
          w_mem_ask_nxt = 1'b0;
          w_state_nxt   = IDLE;
          if (!r_discard && !rob_clear) begin
            w_if_valid_nxt = 1'b1;
            w_if_inst_nxt  = ic_mem_inst;
          end
        end else if (rob_clear) begin
          // The controller cannot abort, so keep asking and drop the result.
          w_discard_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized self-checking bench for icache against a line-level
// reference model (valid/tag/data arrays indexed by the fetch address).
module tb_icache;

  localparam int unsigned IB    = 6;
  localparam int unsigned LINES = 1 << IB;
`ifdef ICACHE_STORAGE_EN
  localparam bit STORE = 1'b1;
`else
  localparam bit STORE = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        ic_mem_ask;
  logic [31:0] ic_mem_addr;
  logic        ic_mem_valid;
  logic [31:0] ic_mem_inst;
  logic        rob_clear;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  logic [31:0] m_data  [LINES];

  icache #(.ICACHE_INDEX_BITS(IB)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .if_req      (if_req),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .ic_mem_ask  (ic_mem_ask),
    .ic_mem_addr (ic_mem_addr),
    .ic_mem_valid(ic_mem_valid),
    .ic_mem_inst (ic_mem_inst),
    .rob_clear   (rob_clear)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc >> 2) % LINES;
  endfunction

  function automatic int unsigned m_tg(input logic [31:0] pc);
    return pc >> (IB + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return STORE && m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
  endfunction

  function automatic void m_fill(input logic [31:0] pc, input logic [31:0] w);
    if (STORE) begin
      m_valid[m_idx(pc)] = 1'b1;
      m_tag[m_idx(pc)]   = m_tg(pc);
      m_data[m_idx(pc)]  = w;
    end
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // One complete fetch: hit served next cycle, or a miss answered after dly idle cycles.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] word, input int dly);
    bit          hit;
    logic [31:0] al;
    hit = m_hit(pc);
    al  = pc & 32'hFFFF_FFFC;
    if_req = 1'b1;
    if_pc  = pc;
    step();
    if (hit) begin
      n_checks++;
      if (if_valid !== 1'b1 || if_inst !== m_data[m_idx(pc)] || ic_mem_ask !== 1'b0) begin
        n_fail++;
        $display("FAIL hit pc=%h: valid=%b inst=%h ask=%b, want valid=1 inst=%h ask=0",
                 pc, if_valid, if_inst, ic_mem_ask, m_data[m_idx(pc)]);
      end
    end else begin
      n_checks++;
      if (ic_mem_ask !== 1'b1 || ic_mem_addr !== al || if_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL miss_ask pc=%h: ask=%b addr=%h valid=%b, want ask=1 addr=%h valid=0",
                 pc, ic_mem_ask, ic_mem_addr, if_valid, al);
      end
      for (int i = 0; i < dly; i++) begin
        step();
        n_checks++;
        if (ic_mem_ask !== 1'b1 || ic_mem_addr !== al) begin
          n_fail++;
          $display("FAIL miss_hold pc=%h: ask=%b addr=%h, want ask=1 addr=%h",
                   pc, ic_mem_ask, ic_mem_addr, al);
        end
      end
      ic_mem_valid = 1'b1;
      ic_mem_inst  = word;
      step();
      ic_mem_valid = 1'b0;
      n_checks++;
      if (if_valid !== 1'b1 || if_inst !== word || ic_mem_ask !== 1'b0) begin
        n_fail++;
        $display("FAIL miss_fill pc=%h: valid=%b inst=%h ask=%b, want valid=1 inst=%h ask=0",
                 pc, if_valid, if_inst, ic_mem_ask, word);
      end
      m_fill(pc, word);
    end
    // Request still held across the result cycle must not be served twice.
    step();
    n_checks++;
    if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0) begin
      n_fail++;
      $display("FAIL no_double pc=%h: valid=%b ask=%b, want 0 0", pc, if_valid, ic_mem_ask);
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; if_pc = 32'h0;
    ic_mem_valid = 1'b0; ic_mem_inst = 32'h0; rob_clear = 1'b0;
    m_clear();
    repeat (3) step();
    rst_in = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || if_inst !== 32'h0 || ic_mem_ask !== 1'b0 || ic_mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: valid=%b inst=%h ask=%b addr=%h, want all 0",
               if_valid, if_inst, ic_mem_ask, ic_mem_addr);
    end
    step();
  endtask

  task automatic test_directed();
    fetch(32'h0000_0000, 32'h0000_0013, 2);
    fetch(32'h0000_0000, 32'h1111_1111, 0);
    fetch(32'h0000_0100, 32'h0000_0093, 1);
    fetch(32'h0000_0000, 32'h0000_0013, 0);
  endtask

  task automatic test_flush();
    // Flush during a miss: word is filled but never presented.
    if_req = 1'b1; if_pc = 32'h0000_0040;
    step();
    n_checks++;
    if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL flush_ask: ask=%b addr=%h, want 1 00000040", ic_mem_ask, ic_mem_addr);
    end
    if_req = 1'b0;
    step();
    rob_clear = 1'b1;
    step();
    rob_clear = 1'b0;
    n_checks++;
    if (ic_mem_ask !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_keep_ask: ask=%b, want 1", ic_mem_ask);
    end
    repeat (2) step();
    ic_mem_valid = 1'b1; ic_mem_inst = 32'hDEAD_BEEF;
    step();
    ic_mem_valid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: valid=%b ask=%b, want 0 0", if_valid, ic_mem_ask);
    end
    m_fill(32'h0000_0040, 32'hDEAD_BEEF);
    step();
    fetch(32'h0000_0040, 32'h0BAD_0040, 1);

    // Flush coincident with the returning word.
    if_req = 1'b1; if_pc = 32'h0000_0080;
    step();
    if_req = 1'b0;
    rob_clear = 1'b1; ic_mem_valid = 1'b1; ic_mem_inst = 32'hCAFE_0080;
    step();
    rob_clear = 1'b0; ic_mem_valid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_same_cycle: valid=%b ask=%b, want 0 0", if_valid, ic_mem_ask);
    end
    m_fill(32'h0000_0080, 32'hCAFE_0080);
    step();
    fetch(32'h0000_0080, 32'h0BAD_0080, 0);

    // Flush in IDLE blocks the request for that cycle.
    if_req = 1'b1; if_pc = 32'h0000_00C0; rob_clear = 1'b1;
    step();
    rob_clear = 1'b0; if_req = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: valid=%b ask=%b, want 0 0", if_valid, ic_mem_ask);
    end
    step();
  endtask

  task automatic test_stall_and_reset();
    if_req = 1'b1; if_pc = 32'h0000_0200;
    step();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h0000_0200 || if_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: ask=%b addr=%h valid=%b, want 1 00000200 0",
                 ic_mem_ask, ic_mem_addr, if_valid);
      end
    end
    rdy_in = 1'b1; if_req = 1'b0; rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    m_clear();
    n_checks++;
    if (ic_mem_ask !== 1'b0 || ic_mem_addr !== 32'h0 || if_valid !== 1'b0 || if_inst !== 32'h0) begin
      n_fail++;
      $display("FAIL miss_reset: ask=%b addr=%h valid=%b inst=%h, want all 0",
               ic_mem_ask, ic_mem_addr, if_valid, if_inst);
    end
    ic_mem_valid = 1'b1; ic_mem_inst = 32'h5555_AAAA;
    step();
    ic_mem_valid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0) begin
      n_fail++;
      $display("FAIL late_valid: valid=%b ask=%b, want 0 0", if_valid, ic_mem_ask);
    end
    step();
    fetch(32'h0000_0040, 32'h0000_4040, 1);
    fetch(32'h0000_0000, 32'h0000_0013, 0);
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int n = 0; n < 60; n++) begin
      pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
         | 32'($urandom_range(0, 3));
      fetch(pc, $urandom, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_stall_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
